// File: rtl/serial_arith_pkg.sv
// Shared definitions for the serial arithmetic library: FSM state encoding
// and a sizing helper for chunk counters.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width for k chunks; never narrower than one bit.
    function automatic int cnt_width(input int k);
        int w;
        w = (k > 32'sd1) ? $clog2(k) : 32'sd1;
        return w;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder, chained by the serial adder to form a CHUNK-bit ripple slice.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_ripple_adder.sv
// Multi-cycle ripple-carry adder: CHUNK bits per clock through a registered carry,
// operands and result exchanged over valid/ready handshakes.
module serial_ripple_adder
    import serial_arith_pkg::*;
#(
    parameter int N     = 8,
    parameter int CHUNK = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         busy
);

    if ((N < 1) || (CHUNK < 1) || ((N % CHUNK) != 0)) begin : g_bad_cfg
        $error("serial_ripple_adder: CHUNK must be >= 1 and divide N");
    end

    localparam int            K        = N / CHUNK;
    localparam int            CW       = cnt_width(K);
    localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t         state_r;
    logic [N-1:0]   a_r;
    logic [N-1:0]   b_r;
    logic [N-1:0]   sum_r;
    logic           carry_r;
    logic           cout_r;
    logic [CW-1:0]  cnt_r;

    logic [CHUNK:0]   c_s;
    logic [CHUNK-1:0] chunk_sum_s;
    logic [N-1:0]     sum_next_s;

    // Ripple chain across the low CHUNK bits of the operand registers
    assign c_s[0] = carry_r;
    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        full_adder u_fa (
            .a    (a_r[i]),
            .b    (b_r[i]),
            .cin  (c_s[i]),
            .sum  (chunk_sum_s[i]),
            .cout (c_s[i+1])
        );
    end

    // New chunk enters at the top, so after K steps the LSB chunk sits at bit 0
    if (CHUNK == N) begin : g_sum_full
        assign sum_next_s = chunk_sum_s;
    end else begin : g_sum_shift
        assign sum_next_s = {chunk_sum_s, sum_r[N-1:CHUNK]};
    end

    // Control FSM, operand/sum shift registers, carry and chunk counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= cin;
                        cnt_r   <= '0;
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    a_r     <= a_r >> CHUNK;
                    b_r     <= b_r >> CHUNK;
                    sum_r   <= sum_next_s;
                    carry_r <= c_s[CHUNK];
                    cnt_r   <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        cout_r  <= c_s[CHUNK];
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Handshake flags decode the state register only; no input reaches an output
    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign busy      = (state_r == RUN) || (state_r == DONE);
    assign sum       = sum_r;
    assign cout      = cout_r;

endmodule

// File: tb/tb_serial_ripple_adder.sv
// Self-checking bench: CHUNK=1 and CHUNK=4 instances, table vectors, hand-written
// corner sequences and a queue scoreboard fed on acceptance, drained on output.
module tb_serial_ripple_adder;

    logic       clk = 1'b0;
    logic       rst, in_valid, out_ready, cin, dsel;
    logic [7:0] a, b;
    int         nvec = 0, nerr = 0, npop = 0, cyc = 0;

    logic       iv1, ir1, ov1, or1, co1, bz1;
    logic [7:0] s1;
    logic       iv4, ir4, ov4, or4, co4, bz4;
    logic [7:0] s4;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign iv1 = in_valid & ~dsel;
    assign or1 = out_ready & ~dsel;
    assign iv4 = in_valid & dsel;
    assign or4 = out_ready & dsel;

    wire       in_ready_m  = dsel ? ir4 : ir1;
    wire       out_valid_m = dsel ? ov4 : ov1;
    wire       busy_m      = dsel ? bz4 : bz1;
    wire       cout_m      = dsel ? co4 : co1;
    wire [7:0] sum_m       = dsel ? s4 : s1;

    serial_ripple_adder #(.N(8), .CHUNK(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b), .cin(cin),
        .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1), .busy(bz1));

    serial_ripple_adder #(.N(8), .CHUNK(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a), .b(b), .cin(cin),
        .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4), .busy(bz4));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       c;
    } vec_t;

    typedef struct {
        logic [7:0] s;
        logic       c;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        nvec++;
        nerr++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", nm, $time);
    endtask

    // Scoreboard: push the reference sum at acceptance, compare at output handshake
    always @(negedge clk) begin
        exp_t e;
        logic [8:0] full;
        if (rst) begin
            q.delete();
        end else begin
            if (in_valid && in_ready_m) begin
                full = {1'b0, a} + {1'b0, b} + {8'd0, cin};
                e.s  = full[7:0];
                e.c  = full[8];
                q.push_back(e);
            end
            if (out_valid_m && out_ready) begin
                if (q.size() == 0) begin
                    timeout("sb_unexpected_result");
                end else begin
                    e = q.pop_front();
                    chk("sb_result", {23'd0, cout_m, sum_m}, {23'd0, e.c, e.s});
                    npop++;
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Returns #1 after the acceptance edge; keep leaves in_valid asserted.
    task automatic accept(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                          input logic keep);
        int n;
        n = 0;
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready_m && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready_m) timeout("accept");
        @(posedge clk); #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid_m && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid_m) timeout("wait_out");
    endtask

    vec_t vt[8];

    initial begin
        int lat, kexp, p0, prev, seen, n;

        vt[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vt[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vt[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vt[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vt[5] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1};
        vt[6] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vt[7] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = 8'h00; b = 8'h00; cin = 1'b0; dsel = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_outputs_c1", {ir1, ov1, bz1, co1, s1}, 12'h800);
        chk("reset_outputs_c4", {ir4, ov4, bz4, co4, s4}, 12'h800);

        // Table vectors on both chunk sizes, with latency and return-to-idle
        for (int d = 0; d < 2; d++) begin
            dsel = d[0];
            kexp = (d == 1) ? 2 : 8;
            do_reset();
            out_ready = 1'b1;
            for (int i = 0; i < 8; i++) begin
                accept(vt[i].a, vt[i].b, vt[i].cin, 1'b0);
                wait_out(lat);
                chk("latency", lat, kexp);
                chk("tbl_sum", {24'd0, sum_m}, {24'd0, vt[i].s});
                chk("tbl_cout", {31'd0, cout_m}, {31'd0, vt[i].c});
                @(posedge clk); #1;
                chk("tbl_back_idle", {29'd0, in_ready_m, out_valid_m, busy_m}, 32'd4);
            end
        end

        // Backpressure in DONE with toggling inputs
        dsel = 1'b0; do_reset(); out_ready = 1'b0;
        accept(8'h5A, 8'h3C, 1'b0, 1'b0);
        wait_out(lat);
        chk("bp_latency", lat, 8);
        p0 = npop;
        for (int i = 0; i < 5; i++) begin
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); in_valid = 1'($urandom);
            @(posedge clk); #1;
            chk("bp_hold", {in_ready_m, out_valid_m, cout_m, sum_m}, 11'h096 | 11'h200);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_released", {29'd0, in_ready_m, out_valid_m, busy_m}, 32'd4);
        repeat (3) @(posedge clk);
        #1 chk("bp_one_transfer", npop - p0, 1);

        // Reset three cycles into a computation
        accept(8'h5A, 8'h3C, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 chk("midrun_busy", {30'd0, busy_m, in_ready_m}, 32'd2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrun_reset_outputs", {in_ready_m, out_valid_m, busy_m, cout_m, sum_m}, 12'h800);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid_m) seen++;
        end
        chk("midrun_no_valid", seen, 0);
        accept(8'h12, 8'h34, 1'b0, 1'b0);
        wait_out(lat);
        chk("post_reset_result", {cout_m, sum_m}, 9'h046);
        @(posedge clk); #1;

        // Back-to-back with in_valid held high: acceptances K+2 apart, none lost
        p0 = npop; prev = 0;
        for (int i = 0; i < 6; i++) begin
            accept(8'(i * 37 + 5), 8'(i * 91 + 200), i[0], 1'b1);
            if (i > 0) chk("b2b_spacing", cyc - prev, 10);
            prev = cyc;
        end
        in_valid = 1'b0;
        n = 0;
        while ((q.size() != 0 || out_valid_m) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_count", npop - p0, 6);

        // Random sweep on CHUNK=4 with random output stalls
        dsel = 1'b1; do_reset();
        p0 = npop;
        for (int i = 0; i < 1000; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            accept(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
            wait_out(lat);
            out_ready = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
        end
        chk("sweep_count", npop - p0, 1000);
        chk("sweep_queue_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
